uart_bus_arbiter: RTL
=====================

// Module: uart_bus_arbiter
// PURPOSE
//  Two-master arbiter in front of the single uart peripheral port (valid/instr/addr/wdata/wstrb/rdata/ready).
//  Master 0 is the instruction-fetch side; master 1 is the data side. The selected request is registered
//  onto the uart port, and the uart response is routed back to the granted master.
//  One transaction is outstanding at a time. Sits between the soc bus split and the uart.
// PARAMETERS
//  FIXED_PRIO      0     0 = round-robin between m0/m1; 1 = m1 (data) always wins a tie
//  TIMEOUT_CYCLES  1024  watchdog limit in clock cycles (used only with UART_ARB_TIMEOUT_EN); must be >= 2
// PORTS
//  clock        in   1   system clock, all logic on rising edge
//  reset        in   1   asynchronous, active-low reset
//  m0_valid     in   1   master 0 request; held high until m0_ready
//  m0_instr     in   1   master 0 instruction-access flag
//  m0_addr      in   32  master 0 byte address
//  m0_wdata     in   32  master 0 write data
//  m0_wstrb     in   4   master 0 byte strobes; 0 = read
//  m0_rdata     out  32  read data, valid when m0_ready=1
//  m0_ready     out  1   one-cycle completion pulse to master 0
//  m1_*         same set as m0_* for master 1
//  uart_valid   out  1   request to uart; registered; held until uart_ready
//  uart_instr   out  1   registered copy of granted instr
//  uart_addr    out  32  registered copy of granted addr
//  uart_wdata   out  32  registered copy of granted wdata
//  uart_wstrb   out  4   registered copy of granted wstrb
//  uart_rdata   in   32  uart read data, valid with uart_ready
//  uart_ready   in   1   uart completion pulse
//  arb_timeout  out  1   one-cycle pulse when the watchdog fires (constant 0 without macro)
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, grant=0, rr_last=1 (m0 is favoured first).
//    All outputs are 0: uart_valid, uart_instr, uart_addr, uart_wdata, uart_wstrb, m*_ready, m*_rdata, arb_timeout.
//  - FSM: IDLE, BUSY.
//  - IDLE: if any mN_valid=1, pick the winner and latch its fields into the uart_* registers.
//    Set uart_valid=1 and go to BUSY at the next edge. Issue latency is 1 cycle from valid to uart_valid.
//  - Winner selection:
//    - Only one requester valid -> that requester.
//    - Both valid, FIXED_PRIO=0 -> the master != rr_last.
//    - Both valid, FIXED_PRIO=1 -> m1.
//  - BUSY: uart_* outputs are stable. Requests from either master are ignored (not queued).
//  - Completion, in BUSY with uart_ready=1:
//    - m<grant>_ready=1 combinationally in the same cycle; the other master's ready stays 0.
//    - m<grant>_rdata=uart_rdata in that cycle; both m*_rdata are 0 otherwise.
//    - At the edge: uart_valid->0, rr_last<=grant, go to IDLE.
//  - Back-to-back: a master that keeps valid high after its ready pulse is treated as a new request in IDLE.
//    Minimum turnaround is 2 cycles per transaction (IDLE issue + >=1 BUSY cycle).
//  - uart_ready while in IDLE is ignored (no mN_ready, no state change).
//  - A granted master dropping valid during BUSY does not abort the transaction. Its ready still pulses on completion.
//  - Reset asserted mid-transaction: immediate return to reset values. The uart port sees uart_valid fall asynchronously.
//  - Widths pass through unchanged; no address decode or translation.
// CONFIGURATION
//  UART_ARB_TIMEOUT_EN defined:
//    - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle without uart_ready.
//    - On the cycle where count == TIMEOUT_CYCLES-1 and uart_ready=0, all of the following happen:
//      m<grant>_ready=1, m<grant>_rdata=32'h0, arb_timeout=1. At the edge, uart_valid->0 and go to IDLE.
//    - A uart_ready arriving in that same cycle takes precedence: normal completion, arb_timeout=0.
//  UART_ARB_TIMEOUT_EN undefined: no counter; arb_timeout tied 0; BUSY waits indefinitely for uart_ready.
// TESTING
//  1. Single read:
//     - Stimulus: m0_valid=1, addr=32'h0010_0000, wstrb=0.
//     - Response: uart_valid=1 one cycle later with the same addr. Uart returns ready with rdata=32'hA5.
//       Same cycle: m0_ready=1, m0_rdata=32'hA5, m1_ready=0.
//  2. Tie, round-robin (FIXED_PRIO=0):
//     - Stimulus: both valid from reset, held through completions.
//     - Response: grant order m0, m1, m0, m1. Each uart_addr matches the granted master.
//  3. Tie, fixed (FIXED_PRIO=1):
//     - Stimulus: both valid continuously for 3 transactions.
//     - Response: m1 is served all 3 times; m0_ready never pulses.
//  4. Write with late m0 arrival:
//     - Stimulus: m1 write wdata=32'h55, wstrb=4'h1. m0_valid rises during BUSY.
//     - Response: uart_wdata/wstrb stay stable until uart_ready. m0 issues 1 cycle after m1_ready.
//  5. Reset mid-BUSY:
//     - Stimulus: drop reset while uart_valid=1.
//     - Response: uart_valid=0 immediately. After release, all outputs are 0 and state is IDLE.
//  6. Timeout (macro on, TIMEOUT_CYCLES=8):
//     - Stimulus: uart never readies.
//     - Response: on the 8th BUSY cycle, m<grant>_ready=1, rdata=0, arb_timeout=1; uart_valid=0 next cycle.
//     - Without the macro: uart_valid remains 1 for more than 8 cycles.

Source files
------------

// File: rtl/uart_bus_arbiter.sv
// Two-master arbiter in front of the uart port: m0 fetch, m1 data.
// One outstanding request, registered issue, combinational return path.
//
// Ports:
//   clock, reset        rising-edge clock, async active-low reset
//   m0_*, m1_*          master request (valid/instr/addr/wdata/wstrb)
//                       and response (rdata/ready)
//   uart_*              registered request to the uart, response in
//   arb_timeout         one-cycle watchdog pulse
//
// Optional feature: define UART_ARB_TIMEOUT_EN to enable the BUSY
// watchdog (TIMEOUT_CYCLES); otherwise arb_timeout is tied low.
module uart_bus_arbiter #(
    parameter int FIXED_PRIO     = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,
    output logic        uart_valid,
    output logic        uart_instr,
    output logic [31:0] uart_addr,
    output logic [31:0] uart_wdata,
    output logic [3:0]  uart_wstrb,
    input  logic [31:0] uart_rdata,
    input  logic        uart_ready,
    output logic        arb_timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state;
    state_t state_nx;

    logic grant;
    logic rr_last;
    logic winner;
    logic any_req;
    logic done;
    logic tmo;

    assign any_req = m0_valid | m1_valid;

    // Tie: round-robin favours whoever was not served last.
    always_comb begin
        winner = m1_valid;
        if (m0_valid && m1_valid) begin
            winner = (FIXED_PRIO != 0) ? 1'b1 : ~rr_last;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt;

    // Held at zero in IDLE so every BUSY entry starts from zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (state == IDLE) begin
            tmo_cnt <= '0;
        end else if (!uart_ready) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    // A real uart_ready in the same cycle wins over the watchdog.
    assign tmo = (state == BUSY) && !uart_ready
                 && (tmo_cnt == TMO_LAST);
`else
    assign tmo = 1'b0;
`endif

    assign arb_timeout = tmo;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        done     = 1'b0;
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        m0_rdata = '0;
        m1_rdata = '0;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (uart_ready || tmo) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                    m0_ready = ~grant;
                    m1_ready = grant;
                    // Watchdog completion returns zero data.
                    if (uart_ready) begin
                        if (grant) begin
                            m1_rdata = uart_rdata;
                        end else begin
                            m0_rdata = uart_rdata;
                        end
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            grant      <= 1'b0;
            rr_last    <= 1'b1;
            uart_valid <= 1'b0;
            uart_instr <= 1'b0;
            uart_addr  <= '0;
            uart_wdata <= '0;
            uart_wstrb <= '0;
        end else if (state == IDLE && any_req) begin
            grant      <= winner;
            uart_valid <= 1'b1;
            uart_instr <= winner ? m1_instr : m0_instr;
            uart_addr  <= winner ? m1_addr  : m0_addr;
            uart_wdata <= winner ? m1_wdata : m0_wdata;
            uart_wstrb <= winner ? m1_wstrb : m0_wstrb;
        end else if (done) begin
            uart_valid <= 1'b0;
            rr_last    <= grant;
        end
    end

endmodule
